// File: rtl/immediate_encoder.sv
// Packs a 32-bit immediate into the immediate fields of a RISC-V instruction word
// through a 2-stage valid/ready pipeline, flagging values that do not fit the format.
module immediate_encoder (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  imm_sel,
    input  logic [31:0] immediate,
    input  logic [31:0] base_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst,
    output logic        out_err,
    input  logic        clr_err,
    output logic [15:0] err_count
);

    logic        r_s1_valid;
    logic [2:0]  r_s1_sel;
    logic [31:0] r_s1_imm;
    logic [31:0] r_s1_base;
    logic        r_s1_err;

    logic        r_s2_valid;
    logic [31:0] r_inst;
    logic        r_err;
    logic [15:0] r_err_cnt;

    logic        w_err;
    logic [31:0] w_pack;
    logic        w_s2_load;
    logic        w_s1_adv;
    logic        w_in_fire;
    logic        w_out_err_hs;

    assign w_s2_load    = !r_s2_valid || out_ready;
    assign w_s1_adv     = r_s1_valid && w_s2_load;
    assign in_ready     = !r_s1_valid || w_s1_adv;
    assign w_in_fire    = in_valid && in_ready;
    assign w_out_err_hs = r_s2_valid && out_ready && r_err;

    // Range check: a signed field fits when all bits above it equal its sign bit.
    always_comb begin
        w_err = 1'b0;
        case (imm_sel)
            3'b000, 3'b001: w_err = ~((&immediate[31:11]) | ~(|immediate[31:11]));
            3'b010:         w_err = ~((&immediate[31:12]) | ~(|immediate[31:12])) | immediate[0];
            3'b011:         w_err = ~((&immediate[31:20]) | ~(|immediate[31:20])) | immediate[0];
            3'b100:         w_err = |immediate[11:0];
            3'b101:         w_err = |immediate[31:12];
            default:        w_err = (|immediate[31:13]) | immediate[0];
        endcase
    end

    always_comb begin
        w_pack = r_s1_base;
        case (r_s1_sel)
            3'b000, 3'b101: w_pack[31:20] = r_s1_imm[11:0];
            3'b001: begin
                w_pack[31:25] = r_s1_imm[11:5];
                w_pack[11:7]  = r_s1_imm[4:0];
            end
            3'b011: begin
                w_pack[31]    = r_s1_imm[20];
                w_pack[30:21] = r_s1_imm[10:1];
                w_pack[20]    = r_s1_imm[11];
                w_pack[19:12] = r_s1_imm[19:12];
            end
            3'b100: w_pack[31:12] = r_s1_imm[31:12];
            default: begin
                w_pack[31]    = r_s1_imm[12];
                w_pack[30:25] = r_s1_imm[10:5];
                w_pack[11:8]  = r_s1_imm[4:1];
                w_pack[7]     = r_s1_imm[11];
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_sel   <= 3'b000;
            r_s1_imm   <= 32'h0;
            r_s1_base  <= 32'h0;
            r_s1_err   <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_sel   <= imm_sel;
                r_s1_imm   <= immediate;
                r_s1_base  <= base_inst;
                r_s1_err   <= w_err;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_valid <= 1'b0;
            r_inst     <= 32'h0;
            r_err      <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_inst <= w_pack;
                r_err  <= r_s1_err;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_cnt <= 16'h0;
        end else if (clr_err) begin
            r_err_cnt <= 16'h0;
        end else if (w_out_err_hs && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign out_valid = r_s2_valid;
    assign inst      = r_inst;
    assign out_err   = r_err;
    assign err_count = r_err_cnt;

endmodule

// File: tb/tb_immediate_encoder.sv
// Self-checking bench for immediate_encoder: directed vectors, backpressure, counter
// saturation/clear, mid-stream reset and random traffic against a behavioural model.
module tb_immediate_encoder;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  imm_sel = 3'b000;
    logic [31:0] immediate = 32'h0;
    logic [31:0] base_inst = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] inst;
    logic        out_err;
    logic        clr_err = 1'b0;
    logic [15:0] err_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [32:0] q[$];
    logic [15:0] m_cnt = 16'h0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_inst = 32'h0;
    logic        prev_err = 1'b0;
    logic        rnd_done = 1'b0;

    immediate_encoder dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid(in_valid), .in_ready(in_ready),
        .imm_sel(imm_sel), .immediate(immediate), .base_inst(base_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .inst(inst), .out_err(out_err),
        .clr_err(clr_err), .err_count(err_count)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: field placement by format, range checks as plain signed/unsigned bounds.
    function automatic logic [32:0] ref_enc(input logic [2:0] sel, input logic [31:0] imm,
                                            input logic [31:0] base);
        int          s;
        logic [31:0] w;
        logic        e;
        s = $signed(imm);
        w = base;
        e = 1'b0;
        case (sel)
            3'd0: begin w[31:20] = imm[11:0]; e = (s < -2048) || (s > 2047); end
            3'd5: begin w[31:20] = imm[11:0]; e = imm > 32'd4095; end
            3'd1: begin
                w[31:25] = imm[11:5]; w[11:7] = imm[4:0];
                e = (s < -2048) || (s > 2047);
            end
            3'd3: begin
                w[31] = imm[20]; w[30:21] = imm[10:1]; w[20] = imm[11]; w[19:12] = imm[19:12];
                e = (s < -(1 << 20)) || (s >= (1 << 20)) || imm[0];
            end
            3'd4: begin w[31:12] = imm[31:12]; e = (imm % 32'd4096) != 32'd0; end
            default: begin
                w[31] = imm[12]; w[30:25] = imm[10:5]; w[11:8] = imm[4:1]; w[7] = imm[11];
                if (sel == 3'd2) e = (s < -4096) || (s > 4095) || imm[0];
                else             e = (imm > 32'd8191) || imm[0];
            end
        endcase
        return {e, w};
    endfunction

    always @(negedge clk_i) begin
        logic [32:0] e_word;
        logic        hs;
        logic        hs_err;
        if (!rst_ni) begin
            q.delete();
            m_cnt = 16'h0;
            prev_stall = 1'b0;
        end else begin
            hs = out_valid && out_ready;
            hs_err = 1'b0;
            chk("err_count", {16'h0, err_count}, {16'h0, m_cnt});
            chk("in_ready", {31'h0, in_ready}, {31'h0, (q.size() < 2) || out_ready});
            if (prev_stall) begin
                chk("stall_inst", inst, prev_inst);
                chk("stall_err", {31'h0, out_err}, {31'h0, prev_err});
            end
            if (out_valid) begin
                chk("valid_has_word", {31'h0, q.size() != 0}, 32'd1);
                if (q.size() != 0) begin
                    e_word = q[0];
                    chk("out_inst", inst, e_word[31:0]);
                    chk("out_err", {31'h0, out_err}, {31'h0, e_word[32]});
                    if (hs) begin
                        hs_err = e_word[32];
                        void'(q.pop_front());
                    end
                end
            end
            if (clr_err) m_cnt = 16'h0;
            else if (hs_err && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (in_valid && in_ready) q.push_back(ref_enc(imm_sel, immediate, base_inst));
            prev_stall = out_valid && !out_ready;
            prev_inst = inst;
            prev_err = out_err;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_word(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] base);
        int n;
        in_valid = 1'b1;
        imm_sel = sel;
        immediate = imm;
        base_inst = base;
        n = 0;
        @(negedge clk_i);
        while (!in_ready && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (!in_ready) chk("accept_timeout", {31'h0, in_ready}, 32'd1);
        @(posedge clk_i); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    task automatic send_check(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] base,
                              input logic [31:0] exp_inst, input logic exp_err, input string tag);
        send_word(sel, imm, base);
        @(posedge clk_i); #1;
        chk({tag, "_lat_valid"}, {31'h0, out_valid}, 32'd1);
        chk({tag, "_inst"}, inst, exp_inst);
        chk({tag, "_err"}, {31'h0, out_err}, {31'h0, exp_err});
        drain();
    endtask

    function automatic logic [31:0] rand_imm();
        case ($urandom % 4)
            0: return $urandom;
            1: return 32'($urandom_range(0, 16383)) - 32'd8192;
            2: return $urandom & 32'hFFFFF000;
            default: return (32'($urandom_range(0, 32'h3FFFFF)) - 32'h200000) & 32'hFFFFFFFE;
        endcase
    endfunction

    initial begin
        #2;
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
        chk("rst_inst", inst, 32'h0);
        chk("rst_out_err", {31'h0, out_err}, 32'd0);
        chk("rst_err_count", {16'h0, err_count}, 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        send_check(3'b000, 32'hFFFFFFFF, 32'h00008093, 32'hFFF08093, 1'b0, "i_neg1");
        send_check(3'b000, 32'h00000800, 32'h00008093, 32'h80008093, 1'b1, "i_ovf");
        chk("err_count_1", {16'h0, err_count}, 32'd1);
        send_check(3'b010, 32'hFFFFFFFC, 32'h00000063, 32'hFE000EE3, 1'b0, "b_neg4");
        send_check(3'b010, 32'h00000003, 32'h00000063, ref_enc(3'b010, 32'h3, 32'h63) & 32'hFFFFFFFF,
                   1'b1, "b_odd");
        send_check(3'b011, 32'h00000800, 32'h000000EF, 32'h001000EF, 1'b0, "j_800");
        send_check(3'b100, 32'h12345000, 32'h000000B7, 32'h123450B7, 1'b0, "u_ok");
        send_check(3'b100, 32'h12345001, 32'h000000B7, 32'h123450B7, 1'b1, "u_low");
        send_check(3'b111, 32'h00001FFE, 32'h00000063, ref_enc(3'b110, 32'h1FFE, 32'h63) & 32'hFFFFFFFF,
                   1'b0, "bz_max");
        send_check(3'b101, 32'h00001000, 32'h00000013, 32'h00000013, 1'b1, "iz_ovf");

        // Backpressure: 4 words offered while the sink stalls for 6 cycles.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 4; i++) send_word(3'b000, 32'(i), 32'h00000013);
                in_valid = 1'b0;
            end
            begin
                repeat (6) begin @(posedge clk_i); #1; end
                chk("bp_in_ready", {31'h0, in_ready}, 32'd0);
                chk("bp_buffered", q.size(), 2);
                chk("bp_inst", inst, 32'h00100013);
                out_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk_i);
                    chk("bp_rate", {31'h0, out_valid}, 32'd1);
                end
            end
        join
        drain();

        // Random traffic with random sink stalls.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    send_word(3'($urandom), rand_imm(), $urandom);
                    if ($urandom % 4 == 0) idle_cycles($urandom % 3);
                end
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk_i); #1;
                    out_ready = ($urandom % 3) != 0;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Saturation.
        clr_err = 1'b1;
        @(posedge clk_i); #1;
        clr_err = 1'b0;
        for (int i = 0; i < 65535; i++) send_word(3'b000, 32'h00000800, 32'h00000013);
        drain();
        chk("sat_full", {16'h0, err_count}, 32'h0000FFFF);
        send_word(3'b000, 32'h00000800, 32'h00000013);
        drain();
        chk("sat_hold", {16'h0, err_count}, 32'h0000FFFF);

        // clr_err coincident with an error handshake.
        fork
            begin
                for (int i = 0; i < 5; i++) send_word(3'b000, 32'h00000800, 32'h00000013);
                in_valid = 1'b0;
            end
            begin
                int n;
                n = 0;
                do begin
                    @(posedge clk_i); #1;
                    n++;
                end while (!(out_valid && out_err) && n < 50);
                chk("clr_found_err", {31'h0, out_valid && out_err}, 32'd1);
                clr_err = 1'b1;
                @(posedge clk_i); #1;
                clr_err = 1'b0;
                chk("clr_wins", {16'h0, err_count}, 32'd0);
            end
        join
        drain();

        // Reset with 2 words buffered.
        out_ready = 1'b0;
        send_word(3'b000, 32'h00000011, 32'h00000013);
        send_word(3'b000, 32'h00000022, 32'h00000013);
        @(posedge clk_i); #3;
        rst_ni = 1'b0;
        #1;
        chk("mrst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("mrst_in_ready", {31'h0, in_ready}, 32'd1);
        chk("mrst_inst", inst, 32'h0);
        chk("mrst_err_count", {16'h0, err_count}, 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        out_ready = 1'b1;
        @(posedge clk_i); #1;
        send_check(3'b000, 32'h00000033, 32'h00000013, 32'h03300013, 1'b0, "post_rst");
        repeat (4) begin @(posedge clk_i); #1; end
        chk("post_rst_idle", {31'h0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/immediate_encoder.md
# immediate_encoder

Packs a 32-bit immediate into the immediate bit fields of a RISC-V instruction word and checks that the value fits. It is the inverse of the pipeline's immediate generator and uses the same 3-bit immediate-select encoding. It is a 2-stage elastic pipeline with valid/ready on both sides. The self-test program loader and the verification stimulus path use it to build instruction words. For any error-free word, feeding the output back through the immediate generator with the same select returns the original immediate.

## Interface
- No parameters.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- imm_sel  input  3  000 I-signed, 001 S, 010 B-signed, 011 J, 100 U, 101 I-zero-extend, 110/111 B-zero-extend.
- immediate  input  32  value to encode.
- base_inst  input  32  opcode/rd/rs1/rs2/funct fields; the immediate bit positions are overwritten.
- out_valid  output  1  encoded word valid.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- inst  output  32  encoded instruction.
- out_err  output  1  immediate out of range or misaligned for imm_sel; qualified by out_valid.
- clr_err  input  1  synchronous clear of err_count.
- err_count  output  16  saturating count of erroneous words delivered.

## Operation
- Stage 1 registers the request and computes the error flag. Stage 2 registers the packed word, which drives inst and out_err directly.
- Packing. Bits not listed come from base_inst.
  - I and I-zero: inst[31:20]=imm[11:0].
  - S: inst[31:25]=imm[11:5]; inst[11:7]=imm[4:0].
  - B and B-zero: inst[31]=imm[12]; [30:25]=imm[10:5]; [11:8]=imm[4:1]; [7]=imm[11].
  - J: inst[31]=imm[20]; [30:21]=imm[10:1]; [20]=imm[11]; [19:12]=imm[19:12].
  - U: inst[31:12]=imm[31:12].
- Error rules:
  - I and S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - U: imm[11:0]≠0.
  - I-zero: imm[31:12]≠0.
  - B-zero: imm[31:13]≠0, or imm[0]=1.
- An erroneous word is still emitted, packed from the truncated bits, with out_err=1. It is never dropped.
- err_count increments by 1 on each output handshake with out_err=1 and saturates at 0xFFFF.
  - If clr_err and an increment occur in the same cycle, clr_err wins and the result is 0.
- Flow control:
  - Stage 2 loads when it is empty or its word is being accepted.
  - Stage 1 advances when stage 2 loads.
  - in_ready = !s1_valid || s1_advance. It is combinational from state and out_ready, and never from in_valid.
- Word order is preserved. There is no loss or duplication under any out_ready pattern.

## Timing
- Reset values: out_valid=0, inst=0, out_err=0, err_count=0, both stage valid bits 0. in_ready=1 while the pipeline is empty, including during reset.
- Latency: a request accepted at edge N gives out_valid=1 with its word after edge N+1 (2 register stages) if out_ready was held high.
- Throughput is 1 word per cycle with out_ready held high.
- With out_ready low, 2 words are buffered, then in_ready drops. inst and out_err hold stable while out_valid && !out_ready.
- Reset asserted mid-operation discards all buffered words immediately. Outputs return to reset values asynchronously.
- imm_sel 110 and 111 behave identically.

## Test plan
- I-type, base 0x00008093:
  - imm 0xFFFFFFFF, sel 000 -> inst 0xFFF08093, err 0, 2 cycles after accept.
  - imm 0x00000800, sel 000 -> inst 0x80008093, err 1, err_count 1.
- B-type, base 0x00000063:
  - imm 0xFFFFFFFC, sel 010 -> 0xFE000EE3, err 0.
  - imm 0x00000003, sel 010 -> err 1.
- J-type, base 0x000000EF, imm 0x800, sel 011 -> 0x001000EF, err 0.
- U-type, base 0x000000B7, sel 100:
  - imm 0x12345000 -> 0x123450B7, err 0.
  - imm 0x12345001 -> 0x123450B7, err 1.
- Backpressure: out_ready=0 for 6 cycles while 4 back-to-back words are offered -> only 2 accepted, in_ready=0, inst stable. Then out_ready=1 -> all 4 delivered in order, 1 per cycle.
- Counter:
  - Preload err_count to 0xFFFF via 65535 errors, then 1 more error -> stays 0xFFFF.
  - clr_err in the same cycle as an error handshake -> 0.
- Reset mid-stream with 2 words buffered -> out_valid 0 and in_ready 1 immediately. After release, the next word emerges with latency 2 and the old words never appear.
